rr_sel_arbiter: RTL and testbench
=================================

Name: rr_sel_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the 4:1 parallel multiplexer and drives its 2-bit select.
- Four sources request the shared 2-bit output path. The arbiter grants one source at a time for a bounded burst of beats, then rotates priority.
- Beats move through a valid/ready handshake with the downstream consumer, so a held select never drops or duplicates data.

Parameters:
- BURST_LEN, 4, maximum beats per grant before forced rotation; legal range 1..16.
- CNT_W, 4, width of the beat counter; must satisfy 2^CNT_W >= BURST_LEN.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  per-source request; bit i = source feeding mux input I(i+1) has data.
- out_ready  input  1  downstream consumer accepts a beat this cycle.
- sel  output  2  registered select to the multiplexer; index of the granted source.
- grant  output  4  registered one-hot grant; all zero when idle.
- out_valid  output  1  current muxed beat is valid; combinational from state and req.
- beat_cnt  output  CNT_W  beats already transferred in the current grant.
- busy  output  1  high while in GRANT state.

Behaviour:
- Reset (async assert, sync release): state=IDLE, sel=0, grant=0000, ptr=0, beat_cnt=0, busy=0, out_valid=0.
- States: IDLE, GRANT.
- The priority pointer ptr (2 bits) names the highest-priority source. Search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- IDLE, req==0: stay in IDLE.
- IDLE, req!=0: pick the first set req bit in search order from ptr. Next edge: sel=pick, grant=1<<pick, beat_cnt=0, state=GRANT.
  - Latency from req to grant is 1 cycle.
- GRANT: out_valid = req[sel]. A transfer happens in any cycle with out_valid && out_ready.
- Transfer with beat_cnt < BURST_LEN-1: beat_cnt increments; grant is held.
- Release condition, evaluated in GRANT:
  - (a) transfer with beat_cnt == BURST_LEN-1; or
  - (b) req[sel]==0 (source withdrew; no transfer that cycle).
- On release: ptr_next = sel+1 mod 4. Re-arbitrate in the same cycle over req using ptr_next.
  - If a source is found: next edge loads the new sel/grant with beat_cnt=0, stays in GRANT, no bubble cycle.
  - If none: state=IDLE, grant=0000, sel holds its last value, beat_cnt=0.
  - The releasing source is eligible again only after all others, because it sits last in search order.
- Stall: out_valid=1, out_ready=0 → sel, grant and beat_cnt hold indefinitely; no forced rotation while stalled.
- Requests from non-granted sources never affect sel mid-burst.
- BURST_LEN=1: rotate after every transfer.
- Counter never exceeds BURST_LEN-1; no wrap-around within a grant.
- Reset asserted mid-burst: all outputs return to reset values immediately (asynchronous), and ptr returns to 0.
- sel changes only on a clock edge, so the downstream mux sees a stable select for the whole cycle.

Test Plan:
- Reset, then req=0101, out_ready=1, BURST_LEN=4 → cycle1: sel=0, grant=0001. Beats on cycles 1-4, beat_cnt 0,1,2,3. Cycle5: sel=2, grant=0100 with no idle gap.
- Single source req=1000 held, out_ready=1 → four beats on sel=3, then re-grant to sel=3 (only requester), beat_cnt restarts at 0.
- Grant on sel=1 with out_ready=0 for 10 cycles → sel=1, beat_cnt frozen, out_valid=1 throughout. Then out_ready=1 completes the remaining beats.
- Granted source drops req after 2 beats, others idle → out_valid=0 that cycle; next edge: state=IDLE, grant=0000, ptr=(sel+1) mod 4.
- All four req high, out_ready=1 → grant sequence 0,1,2,3,0, each holding exactly 4 beats.
- Assert rst mid-burst (sel=2, beat_cnt=2) → grant=0000, sel=0, beat_cnt=0, busy=0 without waiting for a clock edge. After release with req=1111, first grant goes to sel=0.

Source files
------------

// File: rtl/rr_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_sel_arbiter
// Description : Four-source round-robin arbiter driving the 2-bit select of a
//               4:1 multiplexer. Each grant lasts for at most BURST_LEN beats,
//               which are moved over a valid/ready handshake. After a grant
//               ends, priority rotates past the source that just finished.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_sel_arbiter #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic             out_ready,
    output logic [1:0]       sel,
    output logic [3:0]       grant,
    output logic             out_valid,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Counter value of the final beat in a burst
    localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(BURST_LEN - 1);

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic       w_valid;
    logic       w_xfer;
    logic       w_release;
    logic [1:0] w_search_base;
    logic [1:0] w_arb_idx;
    logic [1:0] w_pick;
    logic       w_found;

    // Handshake and burst-termination decode for the current cycle
    always_comb begin
        w_valid   = (state_q == ST_GRANT) && req[sel_q];
        w_xfer    = w_valid && out_ready;
        w_release = (state_q == ST_GRANT) &&
                    (!req[sel_q] || (w_xfer && (beat_cnt_q == C_LAST_BEAT)));
        // A releasing grant searches from the source after it, so the
        // source that just finished is considered last.
        w_search_base = (state_q == ST_GRANT) ? (sel_q + 2'd1) : ptr_q;
    end

    // Find the first requesting source in rotating order from the search base;
    // scanning from the far end lets the nearest hit overwrite the others.
    always_comb begin
        w_found   = 1'b0;
        w_pick    = 2'd0;
        w_arb_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            w_arb_idx = w_search_base + 2'(i);
            if (req[w_arb_idx]) begin
                w_found = 1'b1;
                w_pick  = w_arb_idx;
            end
        end
    end

    // Next-state logic for grant ownership, pointer and beat counter
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    state_d    = ST_GRANT;
                    sel_d      = w_pick;
                    grant_d    = 4'b0001 << w_pick;
                    beat_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    ptr_d      = sel_q + 2'd1;
                    beat_cnt_d = '0;
                    if (w_found) begin
                        // Hand over directly with no idle bubble
                        sel_d   = w_pick;
                        grant_d = 4'b0001 << w_pick;
                    end else begin
                        // sel keeps its last value while idle
                        state_d = ST_IDLE;
                        grant_d = 4'b0000;
                    end
                end else if (w_xfer) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                grant_d    = 4'b0000;
                beat_cnt_d = '0;
            end
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sel_q      <= 2'd0;
            grant_q    <= 4'b0000;
            ptr_q      <= 2'd0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign sel       = sel_q;
    assign grant     = grant_q;
    assign out_valid = w_valid;
    assign beat_cnt  = beat_cnt_q;
    assign busy      = (state_q == ST_GRANT);

endmodule
`default_nettype wire

// File: tb/tb_rr_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_sel_arbiter
// Description : Directed self-checking bench for rr_sel_arbiter. Each step
//               drives req/out_ready, queues the outputs expected in that
//               cycle, then pops and compares them against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_sel_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       out_ready;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       out_valid;
    logic [3:0] beat_cnt;
    logic       busy;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] grant;
        logic [3:0] cnt;
        logic       valid;
        logic       busy;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_no  = 0;

    rr_sel_arbiter #(
        .BURST_LEN(4),
        .CNT_W    (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .out_ready(out_ready),
        .sel      (sel),
        .grant    (grant),
        .out_valid(out_valid),
        .beat_cnt (beat_cnt),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single field comparison
    function automatic void chk(string tag, logic [3:0] obs, logic [3:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp_v);
        end
    endfunction

    task automatic push_exp(input logic [1:0] es, input logic [3:0] eg,
                            input logic [3:0] ec, input logic ev, input logic eb);
        exp_t e;
        e.sel   = es;
        e.grant = eg;
        e.cnt   = ec;
        e.valid = ev;
        e.busy  = eb;
        sb.push_back(e);
    endtask

    // Pop the oldest expectation and compare it with the DUT outputs
    task automatic compare_head();
        exp_t e;
        checks++;
        assert (sb.size() != 0)
        else begin
            failures++;
            $error("FAIL scoreboard_empty step=%0d observed=0 expected=1", step_no);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sel",       {2'b00, sel},       {2'b00, e.sel});
            chk("grant",     grant,              e.grant);
            chk("beat_cnt",  beat_cnt,           e.cnt);
            chk("out_valid", {3'b000, out_valid}, {3'b000, e.valid});
            chk("busy",      {3'b000, busy},      {3'b000, e.busy});
        end
        step_no++;
    endtask

    // One clock cycle: drive inputs, check this cycle's outputs, advance
    task automatic s(input logic [3:0] r, input logic rdy,
                     input logic [1:0] es, input logic [3:0] eg,
                     input logic [3:0] ec, input logic ev, input logic eb);
        req       = r;
        out_ready = rdy;
        push_exp(es, eg, ec, ev, eb);
        #2;
        compare_head();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seq[4];
        rst       = 1'b1;
        req       = 4'b0000;
        out_ready = 1'b0;

        // Reset values
        @(posedge clk);
        #1;
        push_exp(2'd0, 4'b0000, 4'd0, 1'b0, 1'b0);
        #1;
        compare_head();
        rst = 1'b0;

        // Two requesters: full burst on 0, then seamless hand-over to 2
        s(4'b0101, 1'b1, 2'd0, 4'b0000, 4'd0, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++)
            s(4'b0101, 1'b1, 2'd0, 4'b0001, 4'(c), 1'b1, 1'b1);

        // Source 2 withdraws immediately, source 3 takes over
        s(4'b1000, 1'b1, 2'd2, 4'b0100, 4'd0, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++)
            s(4'b1000, 1'b1, 2'd3, 4'b1000, 4'(c), 1'b1, 1'b1);
        // Only requester is re-granted with counter restarted
        s(4'b1000, 1'b1, 2'd3, 4'b1000, 4'd0, 1'b1, 1'b1);
        s(4'b0000, 1'b1, 2'd3, 4'b1000, 4'd1, 1'b0, 1'b1);
        // Idle: grant cleared, sel held
        s(4'b0000, 1'b1, 2'd3, 4'b0000, 4'd0, 1'b0, 1'b0);

        // Stall on sel=1 for 10 cycles, then finish the burst
        s(4'b0010, 1'b1, 2'd3, 4'b0000, 4'd0, 1'b0, 1'b0);
        s(4'b0010, 1'b1, 2'd1, 4'b0010, 4'd0, 1'b1, 1'b1);
        repeat (10)
            s(4'b0010, 1'b0, 2'd1, 4'b0010, 4'd1, 1'b1, 1'b1);
        for (int c = 1; c < 4; c++)
            s(4'b0010, 1'b1, 2'd1, 4'b0010, 4'(c), 1'b1, 1'b1);

        // Withdraw after two beats: release to idle, ptr moves to 2
        s(4'b0010, 1'b1, 2'd1, 4'b0010, 4'd0, 1'b1, 1'b1);
        s(4'b0010, 1'b1, 2'd1, 4'b0010, 4'd1, 1'b1, 1'b1);
        s(4'b0000, 1'b1, 2'd1, 4'b0010, 4'd2, 1'b0, 1'b1);
        s(4'b0000, 1'b1, 2'd1, 4'b0000, 4'd0, 1'b0, 1'b0);
        s(4'b1111, 1'b1, 2'd1, 4'b0000, 4'd0, 1'b0, 1'b0);

        // All requesting: rotation from ptr=2, four beats each
        seq = '{2, 3, 0, 1};
        for (int g = 0; g < 4; g++)
            for (int c = 0; c < 4; c++)
                s(4'b1111, 1'b1, 2'(seq[g]), 4'(1 << seq[g]), 4'(c), 1'b1, 1'b1);
        s(4'b1111, 1'b1, 2'd2, 4'b0100, 4'd0, 1'b1, 1'b1);
        s(4'b1111, 1'b1, 2'd2, 4'b0100, 4'd1, 1'b1, 1'b1);

        // Mid-burst (sel=2, beat_cnt=2) asynchronous reset, checked before any edge
        rst = 1'b1;
        push_exp(2'd0, 4'b0000, 4'd0, 1'b0, 1'b0);
        #1;
        compare_head();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // After reset the pointer is back at 0
        s(4'b1111, 1'b1, 2'd0, 4'b0000, 4'd0, 1'b0, 1'b0);
        s(4'b1111, 1'b1, 2'd0, 4'b0001, 4'd0, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
